// File: rtl/divider_n_pkg.sv
// Shared ALU definitions for the multi-cycle divide unit: FSM encoding and
// the divide-by-zero quotient constant.
package divider_n_pkg;

  localparam int unsigned N_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Quotient reported for a zero divisor; truncated to the operand width at use.
  localparam logic [N_MAX-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/divider_n_if.sv
// Operand/result handshake bundle between the ALU issue logic and the divider.
interface divider_n_if #(
  parameter int unsigned N = 8
);

  logic         io_in_valid;
  logic         io_in_ready;
  logic [N-1:0] io_dividend;
  logic [N-1:0] io_divisor;
  logic         io_out_valid;
  logic         io_out_ready;
  logic [N-1:0] io_quotient;
  logic [N-1:0] io_remainder;
  logic         io_div_by_zero;

  modport master (
    output io_in_valid, io_dividend, io_divisor, io_out_ready,
    input  io_in_ready, io_out_valid, io_quotient, io_remainder, io_div_by_zero
  );

  modport slave (
    input  io_in_valid, io_dividend, io_divisor, io_out_ready,
    output io_in_ready, io_out_valid, io_quotient, io_remainder, io_div_by_zero
  );

endinterface

// File: rtl/divider_n_sub.sv
// Full-adder cell and the W-bit ripple subtractor built from it (A - B as
// A + ~B + 1); shared with the ALU SUB/CMP path.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

module sub_n #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_borrow
);

  logic [W:0] w_c;

  assign w_c[0] = 1'b1;

  for (genvar g = 0; g < W; g++) begin : g_bit
    full_adder u_fa (
      .i_a  (i_a[g]),
      .i_b  (~i_b[g]),
      .i_ci (w_c[g]),
      .o_s  (o_diff[g]),
      .o_co (w_c[g+1])
    );
  end

  // No carry out of the top cell means A < B.
  assign o_borrow = ~w_c[W];

endmodule

// File: rtl/divider_n.sv
// Unsigned N-bit restoring divider: one quotient bit per cycle, valid/ready
// on both the operand and result sides.
module divider_n
  import divider_n_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic        clock,
  input  logic        reset,
  divider_n_if.slave  bus
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned RW = N + 1;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_q;
  logic [N-1:0]   r_d;
  logic [RW-1:0]  r_r;
  logic [CW-1:0]  r_cnt;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_dbz;

  logic [RW-1:0]  w_t;
  logic [RW-1:0]  w_diff;
  logic           w_borrow;
  logic           w_accept;
  logic           w_zero_div;
  logic           w_last_step;
  logic           w_unused_rtop;

  // Trial value: partial remainder shifted left with the next dividend bit.
  assign w_t        = {r_r[N-1:0], r_q[N-1]};
  assign w_zero_div = (bus.io_divisor == '0);

  sub_n #(.W(RW)) u_sub (
    .i_a      (w_t),
    .i_b      ({1'b0, r_d}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last_step = (r_cnt == CW'(N - 1));
    case (r_state)
      ST_IDLE: begin
        if (bus.io_in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_zero_div ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_last_step) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.io_out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered handshake flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_dbz       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_d   <= bus.io_divisor;
        r_cnt <= '0;
        r_dbz <= w_zero_div;
        if (w_zero_div) begin
          r_q <= N'(DIV0_QUOT);
          r_r <= RW'(bus.io_dividend);
        end else begin
          r_q <= bus.io_dividend;
          r_r <= '0;
        end
      end else if (r_state == ST_BUSY) begin
        r_q   <= {r_q[N-2:0], ~w_borrow};
        r_r   <= w_borrow ? w_t : w_diff;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // The partial remainder stays below the divisor, so its top bit is never set after a step.
  assign w_unused_rtop = r_r[N];

  assign bus.io_in_ready    = r_in_ready;
  assign bus.io_out_valid   = r_out_valid;
  assign bus.io_quotient    = r_q;
  assign bus.io_remainder   = r_r[N-1:0];
  assign bus.io_div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_n.sv
// Directed and randomized checks of divider_n against plain-arithmetic division.
module tb_divider_n;

  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  divider_n_if #(.N(N)) bus ();

  divider_n #(.N(N)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full transaction; latency counts edges from the accepting edge to the
  // edge that raises io_out_valid (0 for a zero divisor: visible next cycle).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall, input bit ghost);
    logic [7:0] eq;
    logic [7:0] er;
    logic       edz;
    int         exp_lat;
    int         lat;
    int         wait_n;
    int         q;
    int         r;
    eq      = (b == 8'd0) ? 8'hFF : a / b;
    er      = (b == 8'd0) ? a : a % b;
    edz     = (b == 8'd0);
    exp_lat = (b == 8'd0) ? 0 : N;

    wait_n = 0;
    while (bus.io_in_ready !== 1'b1 && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    chk("in_ready_idle", 32'(bus.io_in_ready), 32'd1);

    bus.io_in_valid  = 1'b1;
    bus.io_dividend  = a;
    bus.io_divisor   = b;
    bus.io_out_ready = (stall == 0);
    @(negedge clk);
    bus.io_in_valid = 1'b0;
    bus.io_dividend = 8'($urandom);
    bus.io_divisor  = 8'($urandom);

    lat = 0;
    while (bus.io_out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("quotient", 32'(bus.io_quotient), 32'(eq));
    chk("remainder", 32'(bus.io_remainder), 32'(er));
    chk("div_by_zero", 32'(bus.io_div_by_zero), 32'(edz));
    if (b != 8'd0) begin
      q = int'(bus.io_quotient);
      r = int'(bus.io_remainder);
      chk("invariant", 32'((q * int'(b) + r == int'(a)) && (r < int'(b))), 32'd1);
    end

    for (int s = 0; s < stall; s++) begin
      if (ghost) begin
        bus.io_in_valid = 1'b1;
        bus.io_dividend = 8'($urandom);
        bus.io_divisor  = 8'($urandom);
      end
      @(negedge clk);
      chk("hold_valid", 32'(bus.io_out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.io_in_ready), 32'd0);
      chk("hold_quotient", 32'(bus.io_quotient), 32'(eq));
      chk("hold_remainder", 32'(bus.io_remainder), 32'(er));
    end

    bus.io_in_valid  = 1'b0;
    bus.io_out_ready = 1'b1;
    @(negedge clk);
    chk("released_valid", 32'(bus.io_out_valid), 32'd0);
    chk("released_in_ready", 32'(bus.io_in_ready), 32'd1);
    bus.io_out_ready = 1'b0;
  endtask

  initial begin
    bit seen;
    logic [7:0] ra;
    logic [7:0] rb;
    int rs;

    rst              = 1'b1;
    bus.io_in_valid  = 1'b0;
    bus.io_dividend  = '0;
    bus.io_divisor   = '0;
    bus.io_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.io_in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.io_out_valid), 32'd0);
    chk("rst_quotient", 32'(bus.io_quotient), 32'd0);
    chk("rst_remainder", 32'(bus.io_remainder), 32'd0);
    chk("rst_div_by_zero", 32'(bus.io_div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'd100, 8'd7, 0, 1'b0);
    run_op(8'd255, 8'd1, 0, 1'b0);
    run_op(8'd255, 8'd255, 0, 1'b0);
    run_op(8'd3, 8'd200, 0, 1'b0);
    run_op(8'd5, 8'd0, 0, 1'b0);
    run_op(8'd200, 8'd9, 5, 1'b1);

    // Reset four cycles into an operation must discard it entirely.
    bus.io_in_valid  = 1'b1;
    bus.io_dividend  = 8'd77;
    bus.io_divisor   = 8'd5;
    bus.io_out_ready = 1'b1;
    @(negedge clk);
    bus.io_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(bus.io_in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.io_out_valid), 32'd0);
    chk("midrst_quotient", 32'(bus.io_quotient), 32'd0);
    chk("midrst_remainder", 32'(bus.io_remainder), 32'd0);
    chk("midrst_div_by_zero", 32'(bus.io_div_by_zero), 32'd0);
    seen = 1'b0;
    repeat (N + 4) begin
      @(negedge clk);
      if (bus.io_out_valid === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);
    bus.io_out_ready = 1'b0;
    run_op(8'd50, 8'd6, 0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      rs = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      run_op(ra, rb, rs, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
